// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants and word functions for the message schedule and compression blocks.
// Holds the round-constant table, the initial hash values, and the small/big sigma helpers.
package sha256_pkg;

    localparam int SHA_WORD_W = 32;
    localparam int SHA_ROUNDS = 64;
    localparam int SHA_BLK_W  = 512;
    localparam int SHA_WIN_N  = 16;
    localparam int SHA_RND_W  = 6;

    typedef logic [SHA_WORD_W-1:0] word_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } sched_state_e;

    localparam word_t K_TABLE [0:SHA_ROUNDS-1] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam word_t IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (SHA_WORD_W - n));
    endfunction

    function automatic word_t ssig0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t ssig1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic word_t csig0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t csig1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

endpackage

// File: rtl/sha256_msg_sched_if.sv
// Block-load handshake plus per-round Wt/Kt stream between the schedule and its consumer.
interface sha256_msg_sched_if;
    import sha256_pkg::*;

    logic [SHA_BLK_W-1:0] blk;
    logic                 load;
    logic                 ready;
    logic                 soc;
    logic                 eoc;
    logic                 wt_valid;
    word_t                Wt;
    word_t                Kt;
    logic [SHA_RND_W-1:0] round;

    modport master (
        input  blk, load,
        output ready, soc, eoc, wt_valid, Wt, Kt, round
    );

    modport slave (
        output blk, load,
        input  ready, soc, eoc, wt_valid, Wt, Kt, round
    );

endinterface

// File: rtl/sha256_k_rom.sv
// Round-constant lookup: 6-bit round index to 32-bit Kt, purely combinational.
module sha256_k_rom
    import sha256_pkg::*;
(
    input  logic [SHA_RND_W-1:0] i_idx,
    output word_t                o_k
);

    assign o_k = K_TABLE[i_idx];

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: loads one 512-bit block and streams Wt/Kt for 64 rounds, one per clock.
// Optional macro SCHED_STALL_EN adds a stall input that freezes the stream while in RUN.
module sha256_msg_sched #(
    parameter int ROUNDS = 64,
    parameter int WORD_W = 32
) (
    input  logic clk,
    input  logic rst,
`ifdef SCHED_STALL_EN
    input  logic stall,
`endif
    sha256_msg_sched_if.master bus
);
    import sha256_pkg::*;

    generate
        if ((ROUNDS != SHA_ROUNDS) || (WORD_W != SHA_WORD_W)) begin : g_param_check
            $error("sha256_msg_sched supports only ROUNDS=64 and WORD_W=32");
        end
    endgenerate

    sched_state_e         r_state, w_state_next;
    word_t                r_win [0:SHA_WIN_N-1];
    word_t                w_win_next [0:SHA_WIN_N-1];
    word_t                w_blk_word [0:SHA_WIN_N-1];
    logic [SHA_RND_W-1:0] r_round, w_round_next;
    word_t                r_wt, w_wt_next;
    word_t                r_kt, w_kt_next;
    logic                 r_valid, w_valid_next;
    logic                 r_soc, w_soc_next;
    logic                 r_eoc, w_eoc_next;
    logic                 r_ready, w_ready_next;

    logic                 w_stall;
    logic                 w_accept;
    logic                 w_advance;
    logic                 w_last;
    logic [SHA_RND_W-1:0] w_k_idx;
    word_t                w_k;
    word_t                w_new_word;

    genvar gi;
    generate
        for (gi = 0; gi < SHA_WIN_N; gi++) begin : g_blk_split
            assign w_blk_word[gi] = bus.blk[SHA_BLK_W-1-gi*SHA_WORD_W -: SHA_WORD_W];
        end
    endgenerate

`ifdef SCHED_STALL_EN
    assign w_stall = stall;
`else
    assign w_stall = 1'b0;
`endif

    assign w_accept  = (r_state == S_IDLE) && bus.load && r_ready;
    assign w_advance = (r_state == S_RUN) && !w_stall;
    assign w_last    = (r_round == SHA_RND_W'(ROUNDS - 1));

    // Window holds W[t..t+15] for the round on the outputs, so W[t+16] uses taps 0, 1, 9, 14.
    assign w_new_word = ssig1(r_win[14]) + r_win[9] + ssig0(r_win[1]) + r_win[0];

    // Kt is looked up for the round about to be presented and registered alongside Wt.
    assign w_k_idx = (r_state == S_IDLE) ? '0 : r_round + SHA_RND_W'(1);

    sha256_k_rom u_k_rom (
        .i_idx (w_k_idx),
        .o_k   (w_k)
    );

    always_comb begin
        w_state_next = r_state;
        w_round_next = r_round;
        w_wt_next    = r_wt;
        w_kt_next    = r_kt;
        w_valid_next = r_valid;
        w_soc_next   = r_soc;
        w_eoc_next   = r_eoc;
        w_ready_next = r_ready;
        w_win_next   = r_win;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_RUN;
                    w_round_next = '0;
                    w_wt_next    = w_blk_word[0];
                    w_kt_next    = w_k;
                    w_valid_next = 1'b1;
                    w_soc_next   = 1'b1;
                    w_eoc_next   = 1'b0;
                    w_ready_next = 1'b0;
                    w_win_next   = w_blk_word;
                end
            end
            S_RUN: begin
                if (w_advance) begin
                    if (w_last) begin
                        w_state_next = S_IDLE;
                        w_round_next = '0;
                        w_wt_next    = '0;
                        w_kt_next    = '0;
                        w_valid_next = 1'b0;
                        w_soc_next   = 1'b0;
                        w_eoc_next   = 1'b0;
                        w_ready_next = 1'b1;
                    end else begin
                        w_round_next = r_round + SHA_RND_W'(1);
                        w_wt_next    = r_win[1];
                        w_kt_next    = w_k;
                        w_soc_next   = 1'b0;
                        w_eoc_next   = (r_round == SHA_RND_W'(ROUNDS - 2));
                        for (int i = 0; i < SHA_WIN_N - 1; i++) begin
                            w_win_next[i] = r_win[i+1];
                        end
                        w_win_next[SHA_WIN_N-1] = w_new_word;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_round <= '0;
            r_wt    <= '0;
            r_kt    <= '0;
            r_valid <= 1'b0;
            r_soc   <= 1'b0;
            r_eoc   <= 1'b0;
            r_ready <= 1'b1;
            r_win   <= '{default: '0};
        end else begin
            r_state <= w_state_next;
            r_round <= w_round_next;
            r_wt    <= w_wt_next;
            r_kt    <= w_kt_next;
            r_valid <= w_valid_next;
            r_soc   <= w_soc_next;
            r_eoc   <= w_eoc_next;
            r_ready <= w_ready_next;
            r_win   <= w_win_next;
        end
    end

    assign bus.ready    = r_ready;
    assign bus.soc      = r_soc;
    assign bus.eoc      = r_eoc;
    assign bus.wt_valid = r_valid;
    assign bus.Wt       = r_wt;
    assign bus.Kt       = r_kt;
    assign bus.round    = r_round;

endmodule

// File: doc/sha256_msg_sched.md
Name: sha256_msg_sched

Overview:
- Producer side of the per-round Wt/Kt interface consumed by the SHA-256 compression block.
- Accepts one padded 512-bit message block and streams the 64 schedule words Wt, with the matching round constants Kt, one round per clock.
- Drives soc/eoc framing so the compression datapath can advance its working variables in lockstep.

Parameters:
- ROUNDS, 64, number of rounds emitted per block; fixed at 64 for SHA-256, range-checked at elaboration.
- WORD_W, 32, word width; only 32 is supported.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- blk  in  512  padded message block; blk[511:480] is word M0, blk[31:0] is M15.
- load  in  1  start request; sampled only while ready=1.
- ready  out  1  high in IDLE; block accepted when load=1 and ready=1.
- soc  out  1  one-cycle pulse coincident with the round-0 beat.
- eoc  out  1  one-cycle pulse coincident with the round-63 beat.
- wt_valid  out  1  Wt/Kt/round valid this cycle.
- Wt  out  32  schedule word for the current round.
- Kt  out  32  round constant for the current round.
- round  out  6  current round index, 0..63.

Behaviour:
- Reset (rst=0 at a clock edge):
  - State goes to IDLE.
  - ready=1 from the first cycle after reset; soc=eoc=wt_valid=0; Wt=Kt=0; round=0.
  - Window registers are cleared.
  - Reset mid-run aborts the block; no eoc is produced.
- States:
  - IDLE -> RUN on load and ready.
  - RUN -> IDLE on the beat with round=63.
  - There are no other states.
- Load cycle N:
  - blk is captured into a 16x32 shift window W[0..15].
  - ready drops at N+1.
- Timing, all outputs registered:
  - Round t is presented at cycle N+1+t (stall not asserted).
  - wt_valid is high for 64 consecutive beats.
  - soc is high at N+1; eoc is high at N+64.
  - ready returns at N+65, which is the earliest cycle a new load is accepted.
  - Back-to-back blocks therefore have a one-cycle gap.
- Word generation:
  - For t<16: Wt = M[t].
  - For t>=16: Wt = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], modulo 2^32 with carries discarded.
  - s0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - s1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- Window handling:
  - The window shifts by one word per beat; the newly computed word enters at the tail.
  - Only 16 words are ever stored.
- Kt: taken from a 64-entry constant table indexed by the round counter.
  - K0=0x428a2f98, K63=0xc67178f2.
- load asserted while ready=0 is ignored; the block in flight is unaffected.
- Round counter: 6 bits.
  - Wraps 63->0 only with the transition to IDLE.
  - round holds 0 in IDLE.
- blk is sampled only at the accept cycle; later changes have no effect.

Optional Feature:
- Macro SCHED_STALL_EN.
- Defined:
  - Adds input port stall (1 bit).
  - While stall=1 in RUN, the window, counter and all outputs hold their values, including a held soc or eoc.
  - stall in IDLE has no effect.
  - Reset overrides stall.
- Undefined:
  - The port is absent.
  - The block advances every cycle exactly as in the timing above.

Decomposition:
- Shared package sha256_pkg holds:
  - the 64-entry K constant array;
  - the IV constants, also used by the compression side;
  - word-width localparams;
  - the s0/s1 functions, with CSigma0/CSigma1 kept alongside for the compression block.
- One natural sub-module, sha256_k_rom:
  - combinational 6-bit index -> 32-bit constant;
  - registered in the parent with Wt.

Test Plan:
- Reset:
  - Hold rst=0 for 3 cycles, release.
  - Then ready=1, wt_valid=0, Wt=0, Kt=0, round=0.
- "abc" block:
  - Load blk=0x61626380 followed by zeros with last word 0x00000018.
  - Expect W0=0x61626380, W1..W14=0, W15=0x00000018.
  - Expect W16=0x61626380, W17=0x000f0000, W18=0x7da86405, W19=0x600003c6.
  - Kt matches K0..K63 on each beat.
- Framing:
  - Load at cycle N.
  - Expect soc at N+1, eoc only at N+64 with round=63, and ready at N+65.
  - A load at N+65 starts the next block with soc at N+66.
- Ignored load:
  - Pulse load with a different blk at round 10.
  - Remaining Wt values are unchanged from the golden model and no extra soc appears.
- Reset mid-run:
  - Drive rst=0 at round 30.
  - Next cycle wt_valid=0 and ready=1, and eoc never fires for that block.
- SCHED_STALL_EN:
  - Stall for 5 cycles at round 20.
  - Wt, Kt and round=20 are held for the 5 cycles.
  - The sequence then resumes identically, and eoc is delayed by exactly 5 cycles.
